// File: rtl/mc_ctrl_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the
// fetch/datapath side (instruction memory, IR, pc, gpr, alu, ext, muxes).
interface mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             im_valid;
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             ir_write;
   logic             pc_write;
   logic             reg_write;
   logic [3:0]       aluop;
   logic             s_num_write;
   logic [1:0]       s_ext;
   logic             s_b;
   logic             halt;
   logic [1:0]       fault;
   logic [CNT_W-1:0] instr_retired;
   logic [CNT_W-1:0] cycle_count;

   modport master (
      output im_valid, op, funct,
      input  ir_write, pc_write, reg_write, aluop, s_num_write, s_ext, s_b,
             halt, fault, instr_retired, cycle_count
   );

   modport slave (
      input  im_valid, op, funct,
      output ir_write, pc_write, reg_write, aluop, s_num_write, s_ext, s_b,
             halt, fault, instr_retired, cycle_count
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer with fetch timeout, illegal
// instruction fault, and retired-instruction / cycle counters.
module mc_ctrl #(
   parameter int FETCH_TIMEOUT = 16,
   parameter int CNT_W         = 32
) (
   input logic     clock,
   input logic     reset,
   mc_ctrl_if.slave bus
);
   localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 1);

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_SLT   = 4'd4;
   localparam logic [3:0] ALU_PASSB = 4'd5;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

   state_t            state;
   state_t            next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout;
   logic              ir_write;
   logic              pc_write;
   logic              reg_write;

   logic              dec_legal;
   logic [3:0]        dec_aluop;
   logic              dec_s_num_write;
   logic              dec_s_b;
   logic [1:0]        dec_s_ext;

   logic [3:0]        aluop_q;
   logic              s_num_write_q;
   logic              s_b_q;
   logic [1:0]        s_ext_q;
   logic [1:0]        fault_q;
   logic [CNT_W-1:0]  retired_q;
   logic [CNT_W-1:0]  cycles_q;

   always_comb begin
      dec_legal       = 1'b1;
      dec_aluop       = ALU_ADD;
      dec_s_num_write = 1'b0;
      dec_s_b         = 1'b0;
      dec_s_ext       = 2'b00;
      case (bus.op)
         6'b000000: begin
            dec_s_num_write = 1'b1;
            case (bus.funct)
               6'b100001: dec_aluop = ALU_ADD;
               6'b100011: dec_aluop = ALU_SUB;
               6'b100100: dec_aluop = ALU_AND;
               6'b100101: dec_aluop = ALU_OR;
               6'b101010: dec_aluop = ALU_SLT;
               default:   dec_legal = 1'b0;
            endcase
         end
         6'b001001: begin
            dec_aluop = ALU_ADD;
            dec_s_b   = 1'b1;
            dec_s_ext = 2'b01;
         end
         6'b001100: begin
            dec_aluop = ALU_AND;
            dec_s_b   = 1'b1;
         end
         6'b001101: begin
            dec_aluop = ALU_OR;
            dec_s_b   = 1'b1;
         end
         6'b001111: begin
            dec_aluop = ALU_PASSB;
            dec_s_b   = 1'b1;
            dec_s_ext = 2'b10;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // A miss is the timeout miss when it would bring the count up to FETCH_TIMEOUT.
   always_comb begin
      next_state = state;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      timeout    = (wait_cnt == WAIT_W'(FETCH_TIMEOUT - 1));
      case (state)
         FETCH: begin
            ir_write = bus.im_valid;
            if (bus.im_valid)
               next_state = DECODE;
            else if (timeout)
               next_state = HALT;
         end
         DECODE:  next_state = dec_legal ? EXEC : HALT;
         EXEC:    next_state = WB;
         WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            next_state = FETCH;
         end
         HALT:    next_state = HALT;
         default: next_state = FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset)
         state <= FETCH;
      else
         state <= next_state;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt      <= '0;
         aluop_q       <= '0;
         s_num_write_q <= 1'b0;
         s_b_q         <= 1'b0;
         s_ext_q       <= '0;
         fault_q       <= '0;
         retired_q     <= '0;
         cycles_q      <= '0;
      end else begin
         if (state != HALT)
            cycles_q <= cycles_q + CNT_W'(1);
         case (state)
            FETCH: begin
               wait_cnt <= bus.im_valid ? '0 : wait_cnt + WAIT_W'(1);
               if (!bus.im_valid && timeout)
                  fault_q <= 2'b10;
            end
            DECODE: begin
               if (dec_legal) begin
                  aluop_q       <= dec_aluop;
                  s_num_write_q <= dec_s_num_write;
                  s_b_q         <= dec_s_b;
                  s_ext_q       <= dec_s_ext;
               end else begin
                  fault_q <= 2'b01;
               end
            end
            WB: begin
               retired_q     <= retired_q + CNT_W'(1);
               aluop_q       <= '0;
               s_num_write_q <= 1'b0;
               s_b_q         <= 1'b0;
               s_ext_q       <= '0;
            end
            default: ;
         endcase
      end
   end

   // Comb strobes are masked by reset so an abandoned instruction never writes.
   assign bus.ir_write      = ir_write & ~reset;
   assign bus.pc_write      = pc_write & ~reset;
   assign bus.reg_write     = reg_write & ~reset;
   assign bus.halt          = (state == HALT) & ~reset;
   assign bus.aluop         = aluop_q;
   assign bus.s_num_write   = s_num_write_q;
   assign bus.s_b           = s_b_q;
   assign bus.s_ext         = s_ext_q;
   assign bus.fault         = fault_q;
   assign bus.instr_retired = retired_q;
   assign bus.cycle_count   = cycles_q;
endmodule
